// File: rtl/db_target_pkg.sv
// Shared types for the emulated MCU target: command codes, flag bundle, LED layout.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
package db_target_pkg;

    typedef enum logic [3:0] {
        CMD_NONE   = 4'd0,
        CMD_PAUSE  = 4'd1,
        CMD_RESUME = 4'd2,
        CMD_REG_RD = 4'd3,
        CMD_MEM_RD = 4'd4,
        CMD_REG_WR = 4'd5,
        CMD_MEM_WR = 4'd6,
        CMD_STEP   = 4'd7,
        CMD_RESET  = 4'd8
    } cmd_t;

    // Field order is highest priority first.
    typedef struct packed {
        logic cmd_reset;
        logic pause;
        logic resume;
        logic step;
        logic mem_wr;
        logic reg_wr;
        logic mem_rd;
        logic reg_rd;
    } cmd_flags_t;

    localparam int LED_CMD_LSB = 0;
    localparam int LED_BE_LSB  = 4;
    localparam int LED_ERR     = 10;
    localparam int LED_PAUSED  = 11;
    localparam int LED_PC_LSB  = 12;

    // Resolve simultaneous flags to one command.
    function automatic cmd_t encode_cmd(input cmd_flags_t f);
        if (f.cmd_reset) return CMD_RESET;
        if (f.pause)     return CMD_PAUSE;
        if (f.resume)    return CMD_RESUME;
        if (f.step)      return CMD_STEP;
        if (f.mem_wr)    return CMD_MEM_WR;
        if (f.reg_wr)    return CMD_REG_WR;
        if (f.mem_rd)    return CMD_MEM_RD;
        if (f.reg_rd)    return CMD_REG_RD;
        return CMD_NONE;
    endfunction

endpackage

// File: rtl/db_pc_ticker.sv
// Emulated program counter: advances by 4 every PC_TICKS running cycles, wraps at MEM_DEPTH*4.
// Latency: pc updates on the clock edge after run/step/clear is seen.
// Backpressure: none; clear beats step beats free-running advance.
module db_pc_ticker #(
    parameter int PC_TICKS  = 25000000,
    parameter int ADDR_W    = 32,
    parameter int MEM_DEPTH = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              step_pulse,
    input  logic              clr_pulse,
    output logic [ADDR_W-1:0] pc
);

    localparam int TICK_W = (PC_TICKS > 1) ? $clog2(PC_TICKS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(PC_TICKS - 1);
    localparam logic [ADDR_W-1:0] PC_LAST   = ADDR_W'((MEM_DEPTH - 1) * 4);

    logic [TICK_W-1:0] tick;
    logic [ADDR_W-1:0] pc_next;

    // Next word address, wrapping back to zero past the last memory word.
    always_comb begin
        pc_next = (pc >= PC_LAST) ? '0 : pc + ADDR_W'(4);
    end

    // Tick counter and pc; step restarts the tick phase so a later resume gets a full period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc   <= '0;
            tick <= '0;
        end else if (clr_pulse) begin
            pc   <= '0;
            tick <= '0;
        end else if (step_pulse) begin
            pc   <= pc_next;
            tick <= '0;
        end else if (run) begin
            if (tick == TICK_LAST) begin
                tick <= '0;
                pc   <= pc_next;
            end else begin
                tick <= tick + TICK_W'(1);
            end
        end
    end

endmodule

// File: rtl/db_target_model.sv
// Emulated MCU target behind mcu_controller: byte-lane memory, register file, pc control, error flag.
// Latency: results registered on the accept edge; busy then held BUSY_CYCLES cycles.
// Backpressure: busy = valid | countdown; valid seen while counting down is silently dropped.
module db_target_model
    import db_target_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int MEM_DEPTH   = 64,
    parameter int RF_DEPTH    = 32,
    parameter int BUSY_CYCLES = 10,
    parameter int PC_TICKS    = 25000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid,
    input  logic                pause,
    input  logic                resume,
    input  logic                step,
    input  logic                cmd_reset,
    input  logic                mem_rd,
    input  logic                mem_wr,
    input  logic                reg_rd,
    input  logic                reg_wr,
    input  logic [DATA_W/8-1:0] mem_be,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   d_in,
    output logic [DATA_W-1:0]   d_rd,
    output logic                busy,
    output logic                error,
    output logic [ADDR_W-1:0]   pc,
    output logic                paused,
    output logic [15:0]         led
);

    localparam int BE_W   = DATA_W / 8;
    localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int RF_AW  = (RF_DEPTH > 1) ? $clog2(RF_DEPTH) : 1;
    localparam logic [ADDR_W-1:0] MEM_LIM   = ADDR_W'(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] RF_LIM    = ADDR_W'(RF_DEPTH);
    localparam logic [7:0]        BUSY_LOAD = 8'(BUSY_CYCLES);

    // Contents survive rst; only power-up clears them.
    logic [DATA_W-1:0] mem [MEM_DEPTH] = '{default: '0};
    logic [DATA_W-1:0] rf  [RF_DEPTH]  = '{default: '0};

    logic [7:0]        busy_cnt;
    logic              accept;
    cmd_flags_t        flags;
    cmd_t              cmd;
    cmd_t              led_cmd;
    logic [3:0]        led_be;
    logic [3:0]        be4;
    logic [MEM_AW-1:0] mem_idx;
    logic [RF_AW-1:0]  rf_idx;
    logic              mem_ok;
    logic              rf_ok;
    logic              cmd_err;
    logic              is_rd;
    logic              is_mem;
    logic [DATA_W-1:0] rd_val;
    logic              mem_we;
    logic              rf_we;
    logic              step_pulse;
    logic              clr_pulse;
    logic              run;

    assign busy    = valid | (busy_cnt != 8'd0);
    assign accept  = valid & (busy_cnt == 8'd0);
    assign flags   = {cmd_reset, pause, resume, step, mem_wr, reg_wr, mem_rd, reg_rd};
    assign mem_idx = addr[MEM_AW-1:0];
    assign rf_idx  = addr[RF_AW-1:0];
    assign be4     = 4'(mem_be);

    // Decode the command and work out legality and read data ahead of the accept edge.
    always_comb begin
        cmd     = encode_cmd(flags);
        mem_ok  = paused && (addr < MEM_LIM);
        rf_ok   = paused && (addr < RF_LIM);
        cmd_err = 1'b0;
        is_rd   = 1'b0;
        is_mem  = 1'b0;
        rd_val  = '0;
        case (cmd)
            CMD_STEP:   cmd_err = !paused;
            CMD_MEM_WR: begin
                cmd_err = !mem_ok;
                is_mem  = 1'b1;
            end
            CMD_MEM_RD: begin
                cmd_err = !mem_ok;
                is_mem  = 1'b1;
                is_rd   = 1'b1;
                if (mem_ok) rd_val = mem[mem_idx];
            end
            CMD_REG_WR: cmd_err = !rf_ok;
            CMD_REG_RD: begin
                cmd_err = !rf_ok;
                is_rd   = 1'b1;
                if (rf_ok && (addr != '0)) rd_val = rf[rf_idx];
            end
            default: ;
        endcase
    end

    // Side-effect strobes; pause suppresses a tick landing on its own accept edge.
    always_comb begin
        mem_we     = accept && (cmd == CMD_MEM_WR) && mem_ok;
        rf_we      = accept && (cmd == CMD_REG_WR) && rf_ok && (addr != '0);
        step_pulse = accept && (cmd == CMD_STEP) && paused;
        clr_pulse  = accept && (cmd == CMD_RESET);
        run        = !paused && !(accept && (cmd == CMD_PAUSE));
    end

    // Byte-lane memory write; held off while rst is asserted.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (mem_be[i]) mem[mem_idx][i*8 +: 8] <= d_in[i*8 +: 8];
            end
        end
    end

    // Register file write; entry 0 is never written.
    always_ff @(posedge clk) begin
        if (!rst && rf_we) rf[rf_idx] <= d_in;
    end

    // Busy countdown, command results and the paused state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_cnt <= 8'd0;
            d_rd     <= '0;
            error    <= 1'b0;
            paused   <= 1'b0;
            led_cmd  <= CMD_NONE;
            led_be   <= 4'd0;
        end else if (accept) begin
            busy_cnt <= BUSY_LOAD;
            error    <= cmd_err;
            led_cmd  <= cmd;
            led_be   <= is_mem ? be4 : 4'd0;
            if (is_rd) d_rd <= rd_val;
            case (cmd)
                CMD_PAUSE:  paused <= 1'b1;
                CMD_RESUME: paused <= 1'b0;
                CMD_RESET:  paused <= 1'b0;
                default: ;
            endcase
        end else if (busy_cnt != 8'd0) begin
            busy_cnt <= busy_cnt - 8'd1;
        end
    end

    // Status display assembled from registered state.
    always_comb begin
        led                       = '0;
        led[LED_CMD_LSB +: 4]     = led_cmd;
        led[LED_BE_LSB +: 4]      = led_be;
        led[LED_ERR]              = error;
        led[LED_PAUSED]           = paused;
        led[LED_PC_LSB +: 4]      = pc[5:2];
    end

    db_pc_ticker #(
        .PC_TICKS  (PC_TICKS),
        .ADDR_W    (ADDR_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_pc_ticker (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .step_pulse (step_pulse),
        .clr_pulse  (clr_pulse),
        .pc         (pc)
    );

endmodule

// File: tb/tb_db_target_model.sv
`timescale 1ns/1ps
module tb_db_target_model;

    localparam int DATA_W      = 32;
    localparam int ADDR_W      = 32;
    localparam int MEM_DEPTH   = 16;
    localparam int RF_DEPTH    = 32;
    localparam int BUSY_CYCLES = 3;
    localparam int PC_TICKS    = 4;

    localparam logic [7:0] F_RESET  = 8'h80;
    localparam logic [7:0] F_PAUSE  = 8'h40;
    localparam logic [7:0] F_RESUME = 8'h20;
    localparam logic [7:0] F_STEP   = 8'h10;
    localparam logic [7:0] F_MEMWR  = 8'h08;
    localparam logic [7:0] F_REGWR  = 8'h04;
    localparam logic [7:0] F_MEMRD  = 8'h02;
    localparam logic [7:0] F_REGRD  = 8'h01;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic        pause = 1'b0, resume = 1'b0, step = 1'b0, cmd_reset = 1'b0;
    logic        mem_rd = 1'b0, mem_wr = 1'b0, reg_rd = 1'b0, reg_wr = 1'b0;
    logic [3:0]  mem_be = '0;
    logic [31:0] addr = '0;
    logic [31:0] d_in = '0;
    logic [31:0] d_rd;
    logic        busy;
    logic        error;
    logic [31:0] pc;
    logic        paused;
    logic [15:0] led;

    int          total = 0;
    int          bad = 0;
    logic [31:0] pc_after;

    typedef struct {
        string       name;
        logic        err;
        bit          chk_d;
        logic [31:0] d;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    db_target_model #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH),
        .RF_DEPTH(RF_DEPTH), .BUSY_CYCLES(BUSY_CYCLES), .PC_TICKS(PC_TICKS)
    ) dut (
        .clk(clk), .rst(rst), .valid(valid),
        .pause(pause), .resume(resume), .step(step), .cmd_reset(cmd_reset),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .reg_rd(reg_rd), .reg_wr(reg_wr),
        .mem_be(mem_be), .addr(addr), .d_in(d_in),
        .d_rd(d_rd), .busy(busy), .error(error), .pc(pc), .paused(paused), .led(led)
    );

    task automatic set_cmd(input logic [7:0] f, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] be);
        {cmd_reset, pause, resume, step, mem_wr, reg_wr, mem_rd, reg_rd} = f;
        addr   = a;
        d_in   = d;
        mem_be = be;
        valid  = 1'b1;
    endtask

    task automatic clr_cmd();
        {cmd_reset, pause, resume, step, mem_wr, reg_wr, mem_rd, reg_rd} = 8'h00;
        valid = 1'b0;
    endtask

    // Queue the expected outcome, drive one valid, then score when busy drops.
    task automatic issue(input string nm, input logic [7:0] f, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be,
                         input logic exp_err, input bit chk_d, input logic [31:0] exp_d);
        exp_t e;
        int   n;
        e.name = nm; e.err = exp_err; e.chk_d = chk_d; e.d = exp_d;
        sb.push_back(e);
        set_cmd(f, a, d, be);
        @(posedge clk);
        @(negedge clk);
        clr_cmd();
        #1;
        pc_after = pc;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
            #1;
        end
        e = sb.pop_front();
        total++;
        if (n !== BUSY_CYCLES) begin bad++; $display("FAIL %s busy_len got=%0d want=%0d", e.name, n, BUSY_CYCLES); end
        total++;
        if (error !== e.err) begin bad++; $display("FAIL %s error got=%b want=%b", e.name, error, e.err); end
        if (e.chk_d) begin
            total++;
            if (d_rd !== e.d) begin bad++; $display("FAIL %s d_rd got=%h want=%h", e.name, d_rd, e.d); end
        end
    endtask

    task automatic test_reset();
        clr_cmd();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (d_rd !== 32'h0)   begin bad++; $display("FAIL reset_d_rd got=%h want=0", d_rd); end
        total++; if (error !== 1'b0)   begin bad++; $display("FAIL reset_error got=%b want=0", error); end
        total++; if (pc !== 32'h0)     begin bad++; $display("FAIL reset_pc got=%h want=0", pc); end
        total++; if (paused !== 1'b0)  begin bad++; $display("FAIL reset_paused got=%b want=0", paused); end
        total++; if (led !== 16'h0)    begin bad++; $display("FAIL reset_led got=%h want=0", led); end
        total++; if (busy !== 1'b0)    begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    endtask

    task automatic test_pc_ticker();
        int n;
        int held;
        repeat (3) @(negedge clk);
        total++; if (pc !== 32'd0)  begin bad++; $display("FAIL tick_pc_3 got=%h want=0", pc); end
        @(negedge clk);
        total++; if (pc !== 32'd4)  begin bad++; $display("FAIL tick_pc_4 got=%h want=4", pc); end
        repeat (59) @(negedge clk);
        total++; if (pc !== 32'd60) begin bad++; $display("FAIL tick_pc_60 got=%h want=3c", pc); end
        @(negedge clk);
        total++; if (pc !== 32'd0)  begin bad++; $display("FAIL tick_wrap got=%h want=0", pc); end
        n = 0;
        while (pc !== 32'd8 && n < 100) begin @(negedge clk); n++; end
        total++; if (pc !== 32'd8)  begin bad++; $display("FAIL tick_reach8 got=%h want=8", pc); end
        // Land the pause on the edge where the tick would otherwise fire.
        repeat (3) @(negedge clk);
        issue("pause_at8", F_PAUSE, 0, 0, 0, 1'b0, 1'b0, 0);
        total++; if (paused !== 1'b1)    begin bad++; $display("FAIL pause_paused got=%b want=1", paused); end
        total++; if (led[3:0] !== 4'd1)  begin bad++; $display("FAIL pause_led_cmd got=%h want=1", led[3:0]); end
        held = 0;
        repeat (20) begin @(negedge clk); if (pc === 32'd8) held++; end
        total++; if (held !== 20)        begin bad++; $display("FAIL pause_hold got=%0d want=20", held); end
        issue("step_paused", F_STEP, 0, 0, 0, 1'b0, 1'b0, 0);
        total++; if (pc !== 32'd12)      begin bad++; $display("FAIL step_pc got=%h want=c", pc); end
        total++; if (paused !== 1'b1)    begin bad++; $display("FAIL step_paused got=%b want=1", paused); end
        total++; if (led[3:0] !== 4'd7)  begin bad++; $display("FAIL step_led_cmd got=%h want=7", led[3:0]); end
        issue("resume", F_RESUME, 0, 0, 0, 1'b0, 1'b0, 0);
        total++; if (paused !== 1'b0)    begin bad++; $display("FAIL resume_paused got=%b want=0", paused); end
        issue("step_running", F_STEP, 0, 0, 0, 1'b1, 1'b0, 0);
        total++; if (pc_after !== 32'd16) begin bad++; $display("FAIL step_running_pc got=%h want=10", pc_after); end
        total++; if (led[10] !== 1'b1)   begin bad++; $display("FAIL step_running_led_err got=%b want=1", led[10]); end
    endtask

    task automatic test_byte_lane();
        issue("bl_pause", F_PAUSE, 0, 0, 0, 1'b0, 1'b0, 0);
        issue("bl_wr_full", F_MEMWR, 2, 32'hAABBCCDD, 4'hF, 1'b0, 1'b0, 0);
        issue("bl_wr_lanes", F_MEMWR, 2, 32'h11223344, 4'h5, 1'b0, 1'b0, 0);
        total++; if (led[7:4] !== 4'h5)  begin bad++; $display("FAIL bl_led_be got=%h want=5", led[7:4]); end
        total++; if (led[3:0] !== 4'd6)  begin bad++; $display("FAIL bl_led_cmd got=%h want=6", led[3:0]); end
        total++; if (led[11] !== 1'b1)   begin bad++; $display("FAIL bl_led_paused got=%b want=1", led[11]); end
        issue("bl_rd", F_MEMRD, 2, 0, 4'h0, 1'b0, 1'b1, 32'hAA22CC44);
    endtask

    task automatic test_illegal();
        issue("il_resume", F_RESUME, 0, 0, 0, 1'b0, 1'b0, 0);
        issue("il_rd_running", F_MEMRD, 1, 0, 0, 1'b1, 1'b1, 32'h0);
        total++; if (led[10] !== 1'b1)   begin bad++; $display("FAIL il_led_err got=%b want=1", led[10]); end
        issue("il_pause", F_PAUSE, 0, 0, 0, 1'b0, 1'b0, 0);
        issue("il_wr_oob", F_MEMWR, 16, 32'hFFFFFFFF, 4'hF, 1'b1, 1'b0, 0);
        issue("il_rd0_clean", F_MEMRD, 0, 0, 0, 1'b0, 1'b1, 32'h0);
        issue("il_rd2_kept", F_MEMRD, 2, 0, 0, 1'b0, 1'b1, 32'hAA22CC44);
        issue("il_regrd3", F_REGRD, 3, 0, 0, 1'b0, 1'b1, 32'h0);
    endtask

    task automatic test_regfile();
        issue("rf_wr0", F_REGWR, 0, 32'h5, 0, 1'b0, 1'b0, 0);
        issue("rf_rd0", F_REGRD, 0, 0, 0, 1'b0, 1'b1, 32'h0);
        issue("rf_wr31", F_REGWR, 31, 32'hDEADBEEF, 0, 1'b0, 1'b0, 0);
        issue("rf_rd31", F_REGRD, 31, 0, 0, 1'b0, 1'b1, 32'hDEADBEEF);
        issue("rf_rd32", F_REGRD, 32, 0, 0, 1'b1, 1'b1, 32'h0);
        issue("rf_wr33", F_REGWR, 33, 32'h1234, 0, 1'b1, 1'b0, 0);
        issue("rf_rd1", F_REGRD, 1, 0, 0, 1'b0, 1'b1, 32'h0);
    endtask

    task automatic test_priority();
        logic [31:0] pcb;
        logic [31:0] pce;
        pcb = pc;
        pce = (pcb + 32'd4) % 32'd64;
        issue("pr_step_regwr", F_STEP | F_REGWR, 9, 32'h99, 0, 1'b0, 1'b0, 0);
        total++; if (pc !== pce)         begin bad++; $display("FAIL pr_step_pc got=%h want=%h", pc, pce); end
        issue("pr_rd9", F_REGRD, 9, 0, 0, 1'b0, 1'b1, 32'h0);
        issue("pr_resume", F_RESUME, 0, 0, 0, 1'b0, 1'b0, 0);
        issue("pr_pause_memwr", F_PAUSE | F_MEMWR, 5, 32'h12345678, 4'hF, 1'b0, 1'b0, 0);
        total++; if (paused !== 1'b1)    begin bad++; $display("FAIL pr_paused got=%b want=1", paused); end
        total++; if (led[3:0] !== 4'd1)  begin bad++; $display("FAIL pr_led_cmd got=%h want=1", led[3:0]); end
        issue("pr_rd5", F_MEMRD, 5, 0, 0, 1'b0, 1'b1, 32'h0);
    endtask

    task automatic test_busy_drop();
        exp_t e;
        int   n;
        e.name = "drop"; e.err = 1'b1; e.chk_d = 1'b1; e.d = 32'h0;
        sb.push_back(e);
        set_cmd(F_MEMRD, 20, 0, 0);
        @(posedge clk);
        @(negedge clk);
        set_cmd(F_REGRD, 31, 0, 0);
        @(posedge clk);
        @(negedge clk);
        clr_cmd();
        #1;
        n = 0;
        while (busy === 1'b1 && n < 40) begin n++; @(negedge clk); #1; end
        e = sb.pop_front();
        total++; if (n !== 2)            begin bad++; $display("FAIL %s busy_tail got=%0d want=2", e.name, n); end
        total++; if (error !== e.err)    begin bad++; $display("FAIL %s error got=%b want=%b", e.name, error, e.err); end
        total++; if (d_rd !== e.d)       begin bad++; $display("FAIL %s d_rd got=%h want=%h", e.name, d_rd, e.d); end
        total++; if (led[3:0] !== 4'd4)  begin bad++; $display("FAIL %s led_cmd got=%h want=4", e.name, led[3:0]); end
    endtask

    task automatic test_cmd_reset();
        issue("cr_first", F_RESET, 0, 0, 0, 1'b0, 1'b0, 0);
        total++; if (pc_after !== 32'd0) begin bad++; $display("FAIL cr_first_pc got=%h want=0", pc_after); end
        issue("cr_pause", F_PAUSE, 0, 0, 0, 1'b0, 1'b0, 0);
        total++; if (pc_after !== 32'd0) begin bad++; $display("FAIL cr_pause_pc got=%h want=0", pc_after); end
        issue("cr_step_a", F_STEP, 0, 0, 0, 1'b0, 1'b0, 0);
        issue("cr_step_b", F_STEP, 0, 0, 0, 1'b0, 1'b0, 0);
        total++; if (pc !== 32'd8)       begin bad++; $display("FAIL cr_pc8 got=%h want=8", pc); end
        total++; if (led[15:12] !== 4'd2) begin bad++; $display("FAIL cr_led_pc got=%h want=2", led[15:12]); end
        issue("cr_paused", F_RESET, 0, 0, 0, 1'b0, 1'b0, 0);
        total++; if (pc_after !== 32'd0) begin bad++; $display("FAIL cr_pc got=%h want=0", pc_after); end
        total++; if (paused !== 1'b0)    begin bad++; $display("FAIL cr_paused got=%b want=0", paused); end
        total++; if (led[3:0] !== 4'd8)  begin bad++; $display("FAIL cr_led_cmd got=%h want=8", led[3:0]); end
    endtask

    task automatic test_async_reset();
        set_cmd(F_MEMRD, 1, 0, 0);
        @(posedge clk);
        @(negedge clk);
        clr_cmd();
        #2;
        total++; if (busy !== 1'b1)      begin bad++; $display("FAIL ar_pre_busy got=%b want=1", busy); end
        total++; if (error !== 1'b1)     begin bad++; $display("FAIL ar_pre_error got=%b want=1", error); end
        total++; if (pc !== 32'd4)       begin bad++; $display("FAIL ar_pre_pc got=%h want=4", pc); end
        rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL ar_busy got=%b want=0", busy); end
        total++; if (error !== 1'b0)     begin bad++; $display("FAIL ar_error got=%b want=0", error); end
        total++; if (pc !== 32'd0)       begin bad++; $display("FAIL ar_pc got=%h want=0", pc); end
        total++; if (led !== 16'h0)      begin bad++; $display("FAIL ar_led got=%h want=0", led); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        issue("ar_pause", F_PAUSE, 0, 0, 0, 1'b0, 1'b0, 0);
        issue("ar_mem_kept", F_MEMRD, 2, 0, 0, 1'b0, 1'b1, 32'hAA22CC44);
        issue("ar_rf_kept", F_REGRD, 31, 0, 0, 1'b0, 1'b1, 32'hDEADBEEF);
    endtask

    initial begin
        test_reset();
        test_pc_ticker();
        test_byte_lane();
        test_illegal();
        test_regfile();
        test_priority();
        test_busy_drop();
        test_cmd_reset();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

endmodule
